// File: rtl/cond_seq_pkg.sv
// Shared types and constants for the branch-sequencing controller:
// FSM state encoding and the branch codes reported on the branch output.
package cond_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_IF   = 2'd1;
    localparam logic [1:0] BR_ELIF = 2'd2;
    localparam logic [1:0] BR_ELSE = 2'd3;

endpackage : cond_seq_pkg

// File: rtl/cond_branch_eval.sv
// Combinational if / else-if / else rule on the (out0,out1) pair; also
// flags when the rule leaves the pair unchanged (fixed point).
module cond_branch_eval
    import cond_seq_pkg::*;
(
    input  logic       cur0,
    input  logic       cur1,
    output logic       nxt0,
    output logic       nxt1,
    output logic [1:0] br,
    output logic       same
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves one unassigned, which would otherwise infer a latch.
        nxt0 = 1'b0;
        nxt1 = 1'b0;
        br   = BR_ELSE;
        if (cur0 && !cur1) begin
            nxt0 = 1'b1;
            nxt1 = 1'b1;
            br   = BR_IF;
        end else if (!cur0 && cur1) begin
            nxt0 = ~cur1;
            nxt1 = cur1;
            br   = BR_ELIF;
        end else begin
            nxt0 = 1'b0;
            nxt1 = 1'b0;
            br   = BR_ELSE;
        end
        same = (nxt0 == cur0) && (nxt1 == cur1);
    end

endmodule : cond_branch_eval

// File: rtl/cond_stmt_sequencer.sv
// Sequencer that loads an initial pair, applies the branch rule once per
// cycle until MAX_ITER or a fixed point, then holds the result until ack.
module cond_stmt_sequencer
    import cond_seq_pkg::*;
#(
    parameter int MAX_ITER   = 4,
    parameter int CNT_W      = 3,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             init0,
    input  logic             init1,
    input  logic             ack,
    output logic             out0,
    output logic             out1,
    output logic [1:0]       branch,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             busy,
    output logic             done
);

    if (MAX_ITER < 1 || (64'd1 << CNT_W) <= 64'(MAX_ITER)) begin : g_bad_param
        $error("cond_stmt_sequencer: need MAX_ITER >= 1 and 2**CNT_W > MAX_ITER");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out0;
    logic             r_out1;
    logic [1:0]       r_branch;
    logic [CNT_W-1:0] r_iter_cnt;

    logic             w_nxt0;
    logic             w_nxt1;
    logic [1:0]       w_br;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             w_fixed;
    logic             w_busy;
    logic             w_done;

    cond_branch_eval u_eval (
        .cur0 (r_out0),
        .cur1 (r_out1),
        .nxt0 (w_nxt0),
        .nxt1 (w_nxt1),
        .br   (w_br),
        .same (w_same)
    );

    // Termination looks at the count and pair this evaluation produces.
    assign w_cnt_inc = r_iter_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(MAX_ITER));
    assign w_fixed   = EARLY_EXIT && w_same;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                w_busy = 1'b1;
                if (w_last || w_fixed) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath only moves on a start in IDLE or on an EVAL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out0     <= 1'b0;
            r_out1     <= 1'b0;
            r_branch   <= BR_NONE;
            r_iter_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_out0     <= init0;
                        r_out1     <= init1;
                        r_branch   <= BR_NONE;
                        r_iter_cnt <= '0;
                    end
                end
                ST_EVAL: begin
                    r_out0     <= w_nxt0;
                    r_out1     <= w_nxt1;
                    r_branch   <= w_br;
                    r_iter_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign out0     = r_out0;
    assign out1     = r_out1;
    assign branch   = r_branch;
    assign iter_cnt = r_iter_cnt;
    assign busy     = w_busy;
    assign done     = w_done;

endmodule : cond_stmt_sequencer

// File: doc/cond_stmt_sequencer.md
Name: cond_stmt_sequencer

Overview:
Clocked controller that sequences the two-register priority if / else-if / else assignment datapath (out0, out1), one branch evaluation per cycle.
- Loads an initial pair on a start request.
- Iterates the branch rule up to MAX_ITER times, or stops early at a fixed point.
- Reports the branch taken and the iteration count.
- Holds the result under a done/ack handshake.
- Serves as the synchronous reference model for branch-sequencing synthesis tests.

Parameters:
MAX_ITER, 4, maximum branch evaluations per run (>=1).
CNT_W, 3, width of iter_cnt; must satisfy 2^CNT_W > MAX_ITER.
EARLY_EXIT, 1, 1 = terminate when an evaluation leaves (out0,out1) unchanged; 0 = always run MAX_ITER evaluations.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  run request, sampled only in IDLE
init0  input  1  initial value for out0, captured with start
init1  input  1  initial value for out1, captured with start
ack  input  1  result acknowledge, sampled only in DONE
out0  output  1  datapath register 0
out1  output  1  datapath register 1
branch  output  2  last branch taken: 0 none, 1 if, 2 else-if, 3 else
iter_cnt  output  CNT_W  evaluations completed in current/last run
busy  output  1  high in EVAL
done  output  1  high in DONE

Behaviour:
- Clocking and reset:
  - Single clock (clk).
  - Reset is synchronous and active-high (rst).
  - rst=1 at an edge forces state IDLE and out0=out1=0, branch=0, iter_cnt=0, busy=0, done=0.
  - Reset overrides all other inputs, including mid-EVAL and in DONE.
- States: IDLE, EVAL, DONE (encoded 2 bits).
- IDLE:
  - busy=0, done=0.
  - out0/out1/branch/iter_cnt hold their last-run values.
  - start=1: next cycle out0<=init0, out1<=init1, branch<=0, iter_cnt<=0, state<=EVAL.
- EVAL, one evaluation per cycle on the current (out0,out1):
  - (1,0) -> (1,1), branch=1.
  - (0,1) -> out0<=~out1, giving (0,1), branch=2.
  - otherwise -> (0,0), branch=3.
  - iter_cnt<=iter_cnt+1 each EVAL cycle.
- Termination, evaluated in the same cycle on the new count and values:
  - Go to DONE if iter_cnt+1==MAX_ITER.
  - Also go to DONE if EARLY_EXIT=1 and the next (out0,out1) equals the current pair.
  - Otherwise remain in EVAL.
- DONE:
  - done=1; all outputs held.
  - ack=1: state<=IDLE next cycle, done drops.
- Latency: start edge to first EVAL result = 2 cycles. done asserts the cycle after the terminating evaluation.
- Input gating:
  - start is ignored in EVAL and DONE, including when asserted together with ack in DONE; it must be re-asserted in IDLE.
  - ack is ignored outside DONE.
- iter_cnt never wraps; MAX_ITER bounds it.
- busy and done are never high together.

Decomposition:
- Shared package cond_seq_pkg holds:
  - state enum (IDLE/EVAL/DONE);
  - branch codes BR_NONE=0, BR_IF=1, BR_ELIF=2, BR_ELSE=3.
- One sub-module, cond_branch_eval: purely combinational next-value logic.
  - Inputs: cur0, cur1.
  - Outputs: nxt0, nxt1, br[1:0], same.
  - Reused by the bench scoreboard.

Test Plan:
1. rst, then start with init=(1,0), EARLY_EXIT=1, MAX_ITER=4. Required per EVAL cycle:
   - (1,1) br=1 cnt=1;
   - (0,0) br=3 cnt=2;
   - (0,0) br=3 cnt=3;
   - then done=1, busy=0.
2. init=(0,1), EARLY_EXIT=1 -> single EVAL giving (0,1) br=2 cnt=1; done next cycle.
3. EARLY_EXIT=0, init=(0,0) -> exactly 4 EVAL cycles, each (0,0) br=3; done with cnt=4.
4. start pulsed during EVAL and in DONE -> no reload, run unaffected. ack in DONE -> IDLE next cycle, done=0, out/branch/cnt held. start in IDLE with init=(1,1) -> (1,1) loaded, then (0,0) br=3.
5. rst asserted on the 2nd EVAL cycle of scenario 1 -> next cycle IDLE, all outputs 0. A following start runs normally.
6. ack and start both high in DONE -> IDLE, no new run. start then asserted in IDLE -> run begins 1 cycle later.
